// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, default latencies
// and the small FSM state type.
package md_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  localparam int MD_MULT_CYCLES_DEF = 5;
  localparam int MD_DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    MD_IDLE,
    MD_RUN
  } md_state_e;

  // Ops that occupy the unit for several cycles and therefore stall D.
  function automatic logic is_multicycle(input logic [2:0] op);
    return op <= MD_DIVU;
  endfunction

endpackage

// File: rtl/md_calc.sv
// Purely combinational arithmetic for md_unit: signed/unsigned product,
// quotient and remainder, plus a divide-by-zero flag.
module md_calc
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             div_by_zero
);

  logic signed [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0]        prod_u;
  logic [WIDTH-1:0]          safe_b;
  logic [WIDTH-1:0]          abs_a, abs_b, safe_abs_b;
  logic [WIDTH-1:0]          mag_q, mag_r, quot_s, rem_s;
  logic [WIDTH-1:0]          quot_u, rem_u;

  assign prod_s = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
  assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

  // Dividing by a substituted 1 keeps the dividers defined when b is zero;
  // the flag tells the top to discard the result.
  assign div_by_zero = (b == '0);
  assign safe_b      = div_by_zero ? WIDTH'(1) : b;

  // Signed divide works on magnitudes, so the most-negative / -1 case wraps
  // naturally to quotient 0x80..0 and remainder 0.
  assign abs_a      = a[WIDTH-1] ? -a : a;
  assign abs_b      = b[WIDTH-1] ? -b : b;
  assign safe_abs_b = div_by_zero ? WIDTH'(1) : abs_b;
  assign mag_q      = abs_a / safe_abs_b;
  assign mag_r      = abs_a % safe_abs_b;
  assign quot_s     = (a[WIDTH-1] ^ b[WIDTH-1]) ? -mag_q : mag_q;
  assign rem_s      = a[WIDTH-1] ? -mag_r : mag_r;

  assign quot_u = a / safe_b;
  assign rem_u  = a % safe_b;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    res_hi = '0;
    res_lo = '0;
    case (op)
      MD_MULT:  {res_hi, res_lo} = prod_s;
      MD_MULTU: {res_hi, res_lo} = prod_u;
      MD_DIV:   begin res_hi = rem_s; res_lo = quot_s; end
      MD_DIVU:  begin res_hi = rem_u; res_lo = quot_u; end
      default:  ;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// Multiply/divide unit with HI/LO registers for the 5-stage pipeline; holds the
// IDLE/RUN FSM, latency counter and the md stall term for the D-stage hazard logic.
module md_unit
  import md_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             md_d,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             stall_md
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] pend_hi_q, pend_hi_d;
  logic [WIDTH-1:0] pend_lo_q, pend_lo_d;
  logic             pend_dz_q, pend_dz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [WIDTH-1:0] calc_hi, calc_lo;
  logic             calc_dz;

  md_calc #(.WIDTH(WIDTH)) u_calc (
    .op          (op),
    .a           (a),
    .b           (b),
    .res_hi      (calc_hi),
    .res_lo      (calc_lo),
    .div_by_zero (calc_dz)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_dz_d = pend_dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      MD_IDLE: begin
        if (start) begin
          if (is_multicycle(op)) begin
            pend_hi_d = calc_hi;
            pend_lo_d = calc_lo;
            pend_dz_d = calc_dz && (op == MD_DIV || op == MD_DIVU);
            cnt_d     = (op == MD_MULT || op == MD_MULTU) ? CNT_W'(MULT_CYCLES)
                                                          : CNT_W'(DIV_CYCLES);
            state_d   = MD_RUN;
          end else if (op == MD_MTHI) begin
            hi_d = a;
          end else if (op == MD_MTLO) begin
            lo_d = a;
          end
        end
      end
      MD_RUN: begin
        // Starts arriving while busy are ignored; the pending result is kept.
        if (cnt_q == CNT_W'(1)) begin
          state_d = MD_IDLE;
          cnt_d   = '0;
          if (!pend_dz_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its next value from the same pre-edge snapshot.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= MD_IDLE;
      cnt_q     <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_dz_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_dz_q <= pend_dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy     = (state_q == MD_RUN);
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign stall_md = md_d && (busy || (start && is_multicycle(op)));

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed cases plus randomized ops checked
// against a wide-integer arithmetic reference model.
module tb_md_unit;

  localparam int W  = 32;
  localparam int MC = 5;
  localparam int DC = 10;

  logic         clk = 1'b0;
  logic         reset, start, md_d;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         busy, stall_md;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_hi = '0;
  logic [W-1:0] exp_lo = '0;

  md_unit #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .md_d     (md_d),
    .busy     (busy),
    .hi       (hi),
    .lo       (lo),
    .stall_md (stall_md)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference model: architectural HI/LO effect and busy length of one op.
  function automatic void predict(input logic [2:0] o, input logic [31:0] x, y,
                                  input logic [31:0] cur_h, cur_l,
                                  output logic [31:0] nh, nl, output int n);
    longint          sx, sy, sq, sr;
    longint unsigned ux, uy, uq, ur;
    logic [63:0]     p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'b0, x};
    uy = {32'b0, y};
    nh = cur_h;
    nl = cur_l;
    n  = 0;
    case (o)
      3'd0: begin p = sx * sy; nh = p[63:32]; nl = p[31:0]; n = MC; end
      3'd1: begin p = ux * uy; nh = p[63:32]; nl = p[31:0]; n = MC; end
      3'd2: begin
        n = DC;
        if (y != 0) begin sq = sx / sy; sr = sx % sy; nl = sq[31:0]; nh = sr[31:0]; end
      end
      3'd3: begin
        n = DC;
        if (y != 0) begin uq = ux / uy; ur = ux % uy; nl = uq[31:0]; nh = ur[31:0]; end
      end
      3'd4: nh = x;
      3'd5: nl = x;
      default: ;
    endcase
  endfunction

  // Called shortly after a falling edge; issues one op and follows it to completion.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, y,
                        input bit hold_md, input bit poke);
    logic [31:0] nh, nl;
    int n, cycles;
    predict(o, x, y, exp_hi, exp_lo, nh, nl, n);
    start = 1'b1; op = o; a = x; b = y; md_d = hold_md;
    #1;
    check("busy_at_start", busy, 0);
    check("stall_at_start", stall_md, hold_md && (o <= 3'd3));
    @(negedge clk);
    start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
    #1;
    cycles = 0;
    while (busy === 1'b1 && cycles < 40) begin
      cycles++;
      check("hi_held", hi, exp_hi);
      check("lo_held", lo, exp_lo);
      if (hold_md) check("stall_busy", stall_md, 1);
      if (poke && cycles == 2) begin start = 1'b1; op = 3'd4; a = $urandom; end
      @(negedge clk);
      start = 1'b0;
      #1;
    end
    check("busy_len", 64'(cycles), 64'(n));
    exp_hi = nh;
    exp_lo = nl;
    check("hi_result", hi, exp_hi);
    check("lo_result", lo, exp_lo);
    if (hold_md) check("stall_release", stall_md, 0);
    md_d = 1'b0;
  endtask

  task automatic check_hilo(input string tag, input logic [31:0] h, l);
    check({tag, "_hi"}, hi, h);
    check({tag, "_lo"}, lo, l);
  endtask

  initial begin
    reset = 1'b1; start = 1'b1; op = 3'd4; a = 32'hDEAD; b = '0; md_d = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0; start = 1'b0;
    #1;
    check("reset_busy", busy, 0);
    check_hilo("reset", 32'h0, 32'h0);
    check("reset_stall", stall_md, 0);

    run_op(3'd0, 32'hFFFFFFFD, 32'd5, 1'b0, 1'b0);
    check_hilo("mult", 32'hFFFFFFFF, 32'hFFFFFFF1);
    run_op(3'd1, 32'hFFFFFFFF, 32'd2, 1'b0, 1'b0);
    check_hilo("multu", 32'h00000001, 32'hFFFFFFFE);
    run_op(3'd2, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0);
    check_hilo("div", 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op(3'd3, 32'd7, 32'd2, 1'b0, 1'b0);
    check_hilo("divu", 32'd1, 32'd3);

    run_op(3'd4, 32'h1234, 32'h0, 1'b0, 1'b0);
    run_op(3'd5, 32'h5678, 32'h0, 1'b0, 1'b0);
    run_op(3'd3, 32'h9999, 32'h0, 1'b0, 1'b0);
    check_hilo("divu_by_zero", 32'h1234, 32'h5678);
    run_op(3'd2, 32'h1111, 32'h0, 1'b0, 1'b0);
    check_hilo("div_by_zero", 32'h1234, 32'h5678);

    run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
    check_hilo("div_ovf", 32'h0, 32'h80000000);
    run_op(3'd6, 32'hAAAA, 32'h3, 1'b0, 1'b0);
    run_op(3'd7, 32'hBBBB, 32'h3, 1'b1, 1'b0);
    check_hilo("nop_ops", 32'h0, 32'h80000000);

    // Reset during the 4th busy cycle of a DIV abandons it.
    start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    check("busy_before_reset", busy, 1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    exp_hi = '0;
    exp_lo = '0;
    check("abort_busy", busy, 0);
    check_hilo("abort", 32'h0, 32'h0);
    run_op(3'd2, 32'd100, 32'd7, 1'b0, 1'b0);
    check_hilo("after_abort", 32'd2, 32'd14);

    run_op(3'd0, 32'hFFFF0003, 32'h00012345, 1'b1, 1'b1);
    run_op(3'd3, 32'hDEADBEEF, 32'h00000100, 1'b1, 1'b1);

    repeat (40) begin
      logic [31:0] rb;
      rb = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
      run_op(3'($urandom_range(0, 7)), $urandom, rb, 1'($urandom), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

endmodule
